tds_readout_packetizer: RTL and testbench

Parametrised N-channel readout packetizer that drains per-channel TDS data FIFOs and packs their words into raw Ethernet frames on an 8-bit AXI-Stream toward the Ethernet MAC TX FIFO. It is the successor to the fixed 8-channel readout controller, generalised in channel count and data width. It adds round-robin arbitration, per-record channel tagging, frame sequence numbering and idle-timeout frame closure. It sits between the channel receive blocks and the Ethernet MAC interface in one clock domain.

---
 rtl/tds_readout_packetizer.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_tds_readout_packetizer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tds_readout_packetizer.sv
// rtl/tds_readout_packetizer.sv - round-robin channel FIFO drain into raw Ethernet frames
// Optional feature macro: TRAILER_CHECKSUM_EN (XOR checksum byte ahead of the record count).
module tds_readout_packetizer #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 120,
  parameter int TH_W   = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [47:0]              d_mac_add,
  input  logic [47:0]              s_mac_add,
  input  logic [TH_W-1:0]          counter_th,
  input  logic [TH_W-1:0]          idle_counter_number_th,
  input  logic [NUM_CH-1:0]        channel_enable,
  input  logic [NUM_CH-1:0]        ch_empty,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_rd,
  output logic [7:0]               tx_axis_fifo_tdata,
  output logic                     tx_axis_fifo_tvalid,
  input  logic                     tx_axis_fifo_tready,
  output logic                     tx_axis_fifo_tlast,
  output logic [15:0]              frame_seq
);

  localparam int NB   = DATA_W / 8;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef TRAILER_CHECKSUM_EN
  localparam int TRL_LAST = 2;
`else
  localparam int TRL_LAST = 1;
`endif
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_REC  = 3'd2;
  localparam logic [2:0] S_SEL  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_TRL  = 3'd5;

  logic [2:0]      r_state;
  logic [CH_W-1:0] r_sel;
  logic            r_mask;
  logic [7:0]      r_idx;
  logic [47:0]     r_dmac;
  logic [47:0]     r_smac;
  logic [15:0]     r_cnt_th;
  logic [TH_W-1:0] r_idle_th;
  logic [TH_W-1:0] r_idle;
  logic [15:0]     r_rec_cnt;
  logic [15:0]     r_seq;
`ifdef TRAILER_CHECKSUM_EN
  logic [7:0]      r_csum;
`endif

  logic [31:0]                w_cth_ext;
  logic [15:0]                w_cth_eff;
  logic [NUM_CH-1:0]          w_elig;
  logic [NUM_CH-1:0]          w_elig_sel;
  logic [CH_W-1:0]            w_pick;
  logic                       w_pick_vld;
  logic [DATA_W-1:0]          w_sel_data;
  logic [127:0]               w_hdr;
  logic [8*(TRL_LAST+1)-1:0]  w_trl;
  logic [7:0]                 w_byte;
  logic                       w_valid;
  logic                       w_last_byte;
  logic                       w_hs;
  logic [TH_W:0]              w_idle_nxt;
  logic                       w_idle_hit;

  // Record limit: 0 behaves as 1, anything beyond the 16-bit counter clamps to 0xFFFF.
  always_comb begin
    w_cth_ext = 32'(counter_th);
    if (w_cth_ext == 32'd0) begin
      w_cth_eff = 16'd1;
    end else if (w_cth_ext > 32'h0000_FFFF) begin
      w_cth_eff = 16'hFFFF;
    end else begin
      w_cth_eff = w_cth_ext[15:0];
    end
  end

  assign w_elig = channel_enable & ~ch_empty;

  // Right after a pop the empty flag is still stale, so the served channel sits out one SEL.
  always_comb begin
    w_elig_sel = w_elig;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_mask && (CH_W'(i) == r_sel)) begin
        w_elig_sel[i] = 1'b0;
      end
    end
  end

  always_comb begin
    int j;
    j          = 0;
    w_pick     = r_sel;
    w_pick_vld = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      j = int'(r_sel) + k;
      if (j >= NUM_CH) begin
        j = j - NUM_CH;
      end
      if (!w_pick_vld && w_elig_sel[j]) begin
        w_pick     = CH_W'(j);
        w_pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == r_sel) begin
        w_sel_data = ch_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_hdr = {r_dmac, r_smac, 16'h88B5, r_seq};
`ifdef TRAILER_CHECKSUM_EN
  assign w_trl = {r_csum, r_rec_cnt};
`else
  assign w_trl = r_rec_cnt;
`endif

  always_comb begin
    w_byte      = 8'h00;
    w_valid     = 1'b0;
    w_last_byte = 1'b0;
    case (r_state)
      S_HDR: begin
        w_valid     = 1'b1;
        w_byte      = w_hdr[(15 - int'(r_idx))*8 +: 8];
        w_last_byte = (r_idx == 8'd15);
      end
      S_REC: begin
        w_valid     = 1'b1;
        if (r_idx == 8'd0) begin
          w_byte = 8'(r_sel);
        end else begin
          w_byte = w_sel_data[(NB - int'(r_idx))*8 +: 8];
        end
        w_last_byte = (r_idx == 8'(NB));
      end
      S_TRL: begin
        w_valid     = 1'b1;
        w_byte      = w_trl[(TRL_LAST - int'(r_idx))*8 +: 8];
        w_last_byte = (r_idx == 8'(TRL_LAST));
      end
      default: begin
        w_valid = 1'b0;
      end
    endcase
  end

  assign w_hs = w_valid && tx_axis_fifo_tready;

  always_comb begin
    ch_rd = '0;
    if ((r_state == S_REC) && w_hs && w_last_byte) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (CH_W'(i) == r_sel) begin
          ch_rd[i] = 1'b1;
        end
      end
    end
  end

  // Counting the current WAIT cycle makes threshold 0 and 1 both close on the first one.
  assign w_idle_nxt = {1'b0, r_idle} + {{TH_W{1'b0}}, 1'b1};
  assign w_idle_hit = (r_idle_th == '0) || (w_idle_nxt == {1'b0, r_idle_th});

  assign tx_axis_fifo_tdata  = w_byte;
  assign tx_axis_fifo_tvalid = w_valid;
  assign tx_axis_fifo_tlast  = (r_state == S_TRL) && w_last_byte;
  assign frame_seq           = r_seq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_sel     <= LAST_CH;
      r_mask    <= 1'b0;
      r_idx     <= 8'd0;
      r_dmac    <= 48'd0;
      r_smac    <= 48'd0;
      r_cnt_th  <= 16'd1;
      r_idle_th <= '0;
      r_idle    <= '0;
      r_rec_cnt <= 16'd0;
      r_seq     <= 16'd0;
`ifdef TRAILER_CHECKSUM_EN
      r_csum    <= 8'h00;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_sel     <= w_pick;
            r_dmac    <= d_mac_add;
            r_smac    <= s_mac_add;
            r_cnt_th  <= w_cth_eff;
            r_idle_th <= idle_counter_number_th;
            r_idx     <= 8'd0;
            r_rec_cnt <= 16'd0;
`ifdef TRAILER_CHECKSUM_EN
            r_csum    <= 8'h00;
`endif
            r_state   <= S_HDR;
          end
        end
        S_HDR: begin
          if (w_hs) begin
            if (w_last_byte) begin
              r_idx   <= 8'd0;
              r_state <= S_REC;
            end else begin
              r_idx <= r_idx + 8'd1;
            end
          end
        end
        S_REC: begin
          if (w_hs) begin
`ifdef TRAILER_CHECKSUM_EN
            r_csum <= r_csum ^ w_byte;
`endif
            if (w_last_byte) begin
              r_idx  <= 8'd0;
              r_mask <= 1'b1;
              if (r_rec_cnt < r_cnt_th) begin
                r_rec_cnt <= r_rec_cnt + 16'd1;
              end
              r_state <= S_SEL;
            end else begin
              r_idx <= r_idx + 8'd1;
            end
          end
        end
        S_SEL: begin
          r_mask <= 1'b0;
          r_idx  <= 8'd0;
          if (r_rec_cnt >= r_cnt_th) begin
            r_state <= S_TRL;
          end else if (w_pick_vld) begin
            r_sel   <= w_pick;
            r_state <= S_REC;
          end else begin
            r_idle  <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_pick_vld) begin
            r_state <= S_SEL;
          end else if (w_idle_hit) begin
            r_idx   <= 8'd0;
            r_state <= S_TRL;
          end else begin
            r_idle <= w_idle_nxt[TH_W-1:0];
          end
        end
        S_TRL: begin
          if (w_hs) begin
            if (w_last_byte) begin
              r_idx   <= 8'd0;
              r_seq   <= r_seq + 16'd1;
              r_state <= S_IDLE;
            end else begin
              r_idx <= r_idx + 8'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tds_readout_packetizer.sv
// tb/tb_tds_readout_packetizer.sv - scoreboard bench for tds_readout_packetizer
module tb_tds_readout_packetizer;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 120;
  localparam int TH_W   = 12;
  localparam int NB     = DATA_W / 8;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [47:0]              d_mac;
  logic [47:0]              s_mac;
  logic [TH_W-1:0]          counter_th;
  logic [TH_W-1:0]          idle_th;
  logic [NUM_CH-1:0]        channel_enable;
  logic [NUM_CH-1:0]        ch_empty;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_rd;
  logic [7:0]               tdata;
  logic                     tvalid;
  logic                     tready;
  logic                     tlast;
  logic [15:0]              frame_seq;

  always #5 clk = ~clk;

  tds_readout_packetizer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TH_W(TH_W)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .d_mac_add              (d_mac),
    .s_mac_add              (s_mac),
    .counter_th             (counter_th),
    .idle_counter_number_th (idle_th),
    .channel_enable         (channel_enable),
    .ch_empty               (ch_empty),
    .ch_data                (ch_data),
    .ch_rd                  (ch_rd),
    .tx_axis_fifo_tdata     (tdata),
    .tx_axis_fifo_tvalid    (tvalid),
    .tx_axis_fifo_tready    (tready),
    .tx_axis_fifo_tlast     (tlast),
    .frame_seq              (frame_seq)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         gap;
    int         rd;
  } exp_t;

  exp_t              q_exp[$];
  logic [DATA_W-1:0] fq[NUM_CH][$];
  logic [DATA_W-1:0] mq[NUM_CH][$];
  logic [NUM_CH-1:0] m_en = '0;
  int                m_last = NUM_CH - 1;
  int                m_seq = 0;
  int                n_cmp = 0;
  int                n_err = 0;
  bit                sb_on = 1'b0;
  bit                gapchk = 1'b0;
  int                tr_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic push_b(input logic [7:0] d, input logic l, input int gap, input int rd);
    exp_t e;
    e.d = d; e.l = l; e.gap = gap; e.rd = rd;
    q_exp.push_back(e);
  endtask

  function automatic int pick();
    for (int k = 1; k <= NUM_CH; k++) begin
      int j;
      j = (m_last + k) % NUM_CH;
      if (m_en[j] && mq[j].size() > 0) return j;
    end
    return -1;
  endfunction

  // Reference: drain every eligible queue into frames using the round-robin and closure rules.
  task automatic run_model(input int cth, input int ith);
    int c, cnt, eff, gap;
    logic [7:0]        cs, b;
    logic [DATA_W-1:0] w;
    logic [127:0]      hdr;
    eff = (cth == 0) ? 1 : cth;
    forever begin
      c = pick();
      if (c < 0) break;
      hdr = {d_mac, s_mac, 16'h88B5, 16'(m_seq)};
      for (int i = 0; i < 16; i++) push_b(8'(hdr >> (8 * (15 - i))), 1'b0, (i == 0) ? -1 : 0, -1);
      cnt = 0; cs = 8'h00; gap = 0;
      forever begin
        w = mq[c].pop_front();
        m_last = c;
        push_b(8'(c), 1'b0, gap, -1);
        cs = cs ^ 8'(c);
        for (int k = 1; k <= NB; k++) begin
          b = 8'(w >> (8 * (NB - k)));
          push_b(b, 1'b0, 0, (k == NB) ? c : -1);
          cs = cs ^ b;
        end
        cnt++;
        if (cnt == eff) begin gap = 1; break; end
        c = pick();
        if (c < 0) begin gap = 1 + ((ith == 0) ? 1 : ith); break; end
        gap = (c == m_last) ? 3 : 1;
      end
`ifdef TRAILER_CHECKSUM_EN
      push_b(cs, 1'b0, gap, -1);
      gap = 0;
`endif
      push_b(8'(cnt >> 8), 1'b0, gap, -1);
      push_b(8'(cnt), 1'b1, 0, -1);
      m_seq = (m_seq + 1) % 65536;
    end
  endtask

  task automatic load(input int ch, input logic [DATA_W-1:0] w);
    fq[ch].push_back(w);
    mq[ch].push_back(w);
  endtask

  task automatic go(input logic [NUM_CH-1:0] en, input int cth, input int ith, input int mode, input bit gc);
    tr_mode    = mode;
    gapchk     = gc;
    counter_th = TH_W'(cth);
    idle_th    = TH_W'(ith);
    m_en       = en;
    run_model(cth, ith);
    channel_enable = en;
  endtask

  task automatic check_reset_outputs();
    chk("rst_ch_rd", 32'(ch_rd), 32'd0);
    chk("rst_tdata", 32'(tdata), 32'd0);
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tlast", 32'(tlast), 32'd0);
    chk("rst_frame_seq", 32'(frame_seq), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    m_last = NUM_CH - 1;
    m_seq  = 0;
    q_exp.delete();
    reset = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (q_exp.size() > 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (q_exp.size() > 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d bytes outstanding, expected 0", q_exp.size());
      q_exp.delete();
    end
    repeat (30) @(posedge clk);
    for (int i = 0; i < NUM_CH; i++) chk("fifo_level", 32'(fq[i].size()), 32'(mq[i].size()));
    chk("frame_seq", 32'(frame_seq), 32'(m_seq));
    @(posedge clk); #1;
  endtask

  // Channel FIFOs: head follows the pop at once, the empty flag lags by one cycle.
  initial begin
    logic [NUM_CH-1:0] pops;
    logic [NUM_CH-1:0] emp_d;
    emp_d    = '1;
    ch_empty = '1;
    ch_data  = '0;
    forever begin
      @(negedge clk);
      pops = ch_rd;
      @(posedge clk); #1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (pops[i] && fq[i].size() > 0) void'(fq[i].pop_front());
      end
      ch_empty = emp_d;
      for (int i = 0; i < NUM_CH; i++) begin
        emp_d[i] = (fq[i].size() == 0);
        ch_data[i*DATA_W +: DATA_W] = (fq[i].size() > 0) ? fq[i][0] : '0;
      end
    end
  end

  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (tr_mode)
        0:       tready = 1'b1;
        1:       tready = ~tready;
        default: tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    logic [7:0] pd;
    logic       pl;
    bit         pstall;
    int         gap;
    exp_t       e;
    pstall = 1'b0; gap = 0; pd = 8'h00; pl = 1'b0;
    forever begin
      @(negedge clk);
      if (!sb_on || reset) begin
        pstall = 1'b0;
        gap    = 0;
      end else begin
        if (pstall) begin
          chk("stall_tvalid", 32'(tvalid), 32'd1);
          chk("stall_tdata", 32'(tdata), 32'(pd));
          chk("stall_tlast", 32'(tlast), 32'(pl));
        end
        if (tvalid && tready) begin
          if (q_exp.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_byte: got 0x%0h expected no output", tdata);
          end else begin
            e = q_exp.pop_front();
            chk("tdata", 32'(tdata), 32'(e.d));
            chk("tlast", 32'(tlast), 32'(e.l));
            chk("ch_rd", 32'(ch_rd), (e.rd >= 0) ? (32'd1 << e.rd) : 32'd0);
            if (gapchk && e.gap >= 0) chk("bubble_gap", 32'(gap), 32'(e.gap));
          end
          gap    = 0;
          pstall = 1'b0;
        end else begin
          if (ch_rd != '0) chk("ch_rd_no_handshake", 32'(ch_rd), 32'd0);
          if (!tvalid) gap++;
          pstall = tvalid;
          pd     = tdata;
          pl     = tlast;
        end
      end
    end
  end

  initial begin
    logic [127:0] t;
    int           n;
    reset          = 1'b1;
    d_mac          = 48'h0A1B_2C3D_4E5F;
    s_mac          = 48'h0011_2233_4455;
    counter_th     = '0;
    idle_th        = '0;
    channel_enable = '0;
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    do_reset();
    sb_on = 1'b1;

    // two words on channel 1, two records per frame
    load(1, {$urandom(), $urandom(), $urandom(), $urandom()});
    load(1, {$urandom(), $urandom(), $urandom(), $urandom()});
    go(4'b1111, 2, 5, 0, 1'b1);
    wait_done();

    // channels 0, 2, 3 one word each, idle timeout closes the frame
    do_reset();
    for (int c = 0; c < NUM_CH; c++) if (c != 1) load(c, {$urandom(), $urandom(), $urandom(), $urandom()});
    go(4'b1111, 10, 5, 0, 1'b1);
    wait_done();

    // same pattern under alternating backpressure
    do_reset();
    for (int c = 0; c < NUM_CH; c++) if (c != 1) load(c, {$urandom(), $urandom(), $urandom(), $urandom()});
    go(4'b1111, 10, 5, 1, 1'b0);
    wait_done();

    // disabled channel holds data until enabled
    load(2, {$urandom(), $urandom(), $urandom(), $urandom()});
    go(4'b1011, 3, 2, 0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    m_en = 4'b1111;
    run_model(3, 2);
    channel_enable = 4'b1111;
    @(negedge clk);
    chk("enable_latency_pre", 32'(tvalid), 32'd0);
    @(negedge clk);
    chk("enable_latency_post", 32'(tvalid), 32'd1);
    wait_done();

    // reset in the middle of a header
    sb_on = 1'b0;
    load(0, {$urandom(), $urandom(), $urandom(), $urandom()});
    tr_mode = 0;
    n = 0;
    while (!tvalid && n < 50) begin @(negedge clk); n++; end
    chk("hdr_started", 32'(tvalid), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    q_exp.delete();
    m_last = NUM_CH - 1;
    m_seq  = 0;
    sb_on  = 1'b1;
    go(4'b1111, 4, 3, 0, 1'b1);
    reset = 1'b0;
    wait_done();

    // single all-0xA5 record
    load(0, {15{8'hA5}});
    go(4'b1111, 1, 4, 0, 1'b1);
    wait_done();

    // randomized rounds
    for (int r = 0; r < 8; r++) begin
      d_mac = {$urandom(), $urandom()};
      s_mac = {$urandom(), $urandom()};
      for (int c = 0; c < NUM_CH; c++) begin
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) begin
          t = {$urandom(), $urandom(), $urandom(), $urandom()};
          load(c, t[DATA_W-1:0]);
        end
      end
      go(NUM_CH'($urandom_range(1, 15)), $urandom_range(0, 4), $urandom_range(0, 6), r % 3, (r % 3) == 0);
      wait_done();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
